// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared types for the piece-move scheduler and the board.
//                move_cmd_e  - 3-bit command code sent to the board
//                sched_state_e - scheduler FSM state
//                SRC_*       - bit index of each request source in the
//                              pending vector
//  Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_ROTATE = 3'd3,
        CMD_DOWN   = 3'd4,
        CMD_LOCK   = 3'd5,
        CMD_SPAWN  = 3'd6
    } move_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OVER  = 2'd3
    } sched_state_e;

    localparam int NUM_SRC    = 5;
    localparam int SRC_GRAV   = 0;
    localparam int SRC_DOWN   = 1;
    localparam int SRC_ROTATE = 2;
    localparam int SRC_LEFT   = 3;
    localparam int SRC_RIGHT  = 4;

    // Player-originated sources; dropped when a fresh piece spawns.
    localparam logic [NUM_SRC-1:0] USER_SRC_MASK = 5'b11110;

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/gravity_timer.sv
`default_nettype none
// ============================================================================
//  Module      : gravity_timer
//  Description : Free-running gravity divider. Counts 0..GRAVITY_DIV-1 while
//                run is high and pulses tick for the cycle it wraps.
//  Ports       : clk   - system clock
//                reset - asynchronous, active-low reset
//                run   - count enable
//                clear - restart the period from zero (wins over run)
//                tick  - one-cycle pulse on wrap
//  Revision    : 1.0 - initial release
// ============================================================================
module gravity_timer #(
    parameter int GRAVITY_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W   = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GRAVITY_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            if (count_q == CNT_MAX) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : gravity_timer
`default_nettype wire

// File: rtl/tetris_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_move_scheduler
//  Description : Latches key pulses and gravity ticks, arbitrates them into a
//                single in-flight board command (valid/ready + response), and
//                issues LOCK/SPAWN automatically after a failed drop.
//  Ports       : clk, reset (async, active-low)
//                enable                     - game running
//                rotate/down/left/right     - single-cycle key pulses
//                cmd, cmd_valid, cmd_ready  - command offer to the board
//                resp_valid, resp_ok        - board completion response
//                busy                       - command offered or in flight
//                game_over                  - sticky until reset
//  Revision    : 1.0 - initial release
// ============================================================================
module tetris_move_scheduler
    import tetris_pkg::*;
#(
    parameter int GRAVITY_DIV = 50_000_000
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      enable,
    input  logic      rotate,
    input  logic      down,
    input  logic      left,
    input  logic      right,
    output move_cmd_e cmd,
    output logic      cmd_valid,
    input  logic      cmd_ready,
    input  logic      resp_valid,
    input  logic      resp_ok,
    output logic      busy,
    output logic      game_over
);

    sched_state_e       state_q, state_d;
    move_cmd_e          cmd_q, cmd_d;
    logic               src_grav_q, src_grav_d;   // current DOWN came from gravity
    logic               spawn_req_q, spawn_req_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;

    logic               accepting;
    logic               grav_tick;
    logic               grav_clear;
    logic               user_flush;
    logic [NUM_SRC-1:0] req_set;
    logic [NUM_SRC-1:0] grant_clr;

    assign accepting = enable && (state_q != ST_OVER);

    gravity_timer #(
        .GRAVITY_DIV (GRAVITY_DIV)
    ) u_gravity_timer (
        .clk   (clk),
        .reset (reset),
        .run   (accepting),
        .clear (grav_clear),
        .tick  (grav_tick)
    );

    always_comb begin
        req_set = '0;
        if (accepting) begin
            req_set[SRC_GRAV]   = grav_tick;
            req_set[SRC_DOWN]   = down;
            req_set[SRC_ROTATE] = rotate;
            req_set[SRC_LEFT]   = left;
            req_set[SRC_RIGHT]  = right;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        src_grav_d  = src_grav_q;
        spawn_req_d = spawn_req_q;
        grant_clr   = '0;
        grav_clear  = 1'b0;
        user_flush  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (spawn_req_q) begin
                        cmd_d       = CMD_SPAWN;
                        src_grav_d  = 1'b0;
                        spawn_req_d = 1'b0;
                        state_d     = ST_ISSUE;
                    end else if (pend_q[SRC_GRAV]) begin
                        cmd_d               = CMD_DOWN;
                        src_grav_d          = 1'b1;
                        grant_clr[SRC_GRAV] = 1'b1;
                        state_d             = ST_ISSUE;
                    end else if (pend_q[SRC_DOWN]) begin
                        cmd_d               = CMD_DOWN;
                        src_grav_d          = 1'b0;
                        grant_clr[SRC_DOWN] = 1'b1;
                        state_d             = ST_ISSUE;
                    end else if (pend_q[SRC_ROTATE]) begin
                        cmd_d                 = CMD_ROTATE;
                        src_grav_d            = 1'b0;
                        grant_clr[SRC_ROTATE] = 1'b1;
                        state_d               = ST_ISSUE;
                    end else if (pend_q[SRC_LEFT]) begin
                        cmd_d               = CMD_LEFT;
                        src_grav_d          = 1'b0;
                        grant_clr[SRC_LEFT] = 1'b1;
                        state_d             = ST_ISSUE;
                    end else if (pend_q[SRC_RIGHT]) begin
                        cmd_d                = CMD_RIGHT;
                        src_grav_d           = 1'b0;
                        grant_clr[SRC_RIGHT] = 1'b1;
                        state_d              = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (resp_valid) begin
                    state_d = ST_IDLE;
                    case (cmd_q)
                        CMD_DOWN: begin
                            if (!resp_ok) begin
                                // Blocked drop: lock straight away, even if
                                // enable has fallen meanwhile.
                                cmd_d      = CMD_LOCK;
                                src_grav_d = 1'b0;
                                state_d    = ST_ISSUE;
                            end else if (!src_grav_q) begin
                                grav_clear = 1'b1;
                            end
                        end
                        CMD_LOCK: begin
                            spawn_req_d = 1'b1;
                        end
                        CMD_SPAWN: begin
                            if (resp_ok) begin
                                user_flush = 1'b1;
                                grav_clear = 1'b1;
                            end else begin
                                state_d = ST_OVER;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_OVER: ;

            default: state_d = ST_IDLE;
        endcase

        // A fresh pulse in the grant cycle re-arms the bit it just cleared.
        pend_d = (pend_q & ~grant_clr) | req_set;
        if (user_flush) begin
            pend_d = pend_d & ~USER_SRC_MASK;
        end
        if (state_q == ST_OVER) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_NONE;
            src_grav_q  <= 1'b0;
            spawn_req_q <= 1'b1;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            src_grav_q  <= src_grav_d;
            spawn_req_q <= spawn_req_d;
            pend_q      <= pend_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = (state_q == ST_ISSUE);
    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign game_over = (state_q == ST_OVER);

endmodule : tetris_move_scheduler
`default_nettype wire

// File: tb/tb_tetris_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tetris_move_scheduler
//  Description : Directed bench. u_dut (long gravity period) exercises the
//                handshake and arbitration; u_grav (GRAVITY_DIV=8) exercises
//                gravity timing and game over. Both share stimulus; the idle
//                one is held in reset and an observation mux selects outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tetris_move_scheduler;
    import tetris_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic      rst_m_n, rst_g_n;
    logic      enable, rotate, down, left, right;
    logic      cmd_ready, resp_valid, resp_ok;
    move_cmd_e m_cmd, g_cmd;
    logic      m_cmd_valid, m_busy, m_game_over;
    logic      g_cmd_valid, g_busy, g_game_over;

    logic       use_g;
    logic [2:0] o_cmd;
    logic       o_valid, o_busy, o_over;
    assign o_cmd   = use_g ? g_cmd       : m_cmd;
    assign o_valid = use_g ? g_cmd_valid : m_cmd_valid;
    assign o_busy  = use_g ? g_busy      : m_busy;
    assign o_over  = use_g ? g_game_over : m_game_over;

    tetris_move_scheduler #(.GRAVITY_DIV(1024)) u_dut (
        .clk(clk), .reset(rst_m_n), .enable(enable),
        .rotate(rotate), .down(down), .left(left), .right(right),
        .cmd(m_cmd), .cmd_valid(m_cmd_valid), .cmd_ready(cmd_ready),
        .resp_valid(resp_valid), .resp_ok(resp_ok),
        .busy(m_busy), .game_over(m_game_over)
    );

    tetris_move_scheduler #(.GRAVITY_DIV(8)) u_grav (
        .clk(clk), .reset(rst_g_n), .enable(enable),
        .rotate(rotate), .down(down), .left(left), .right(right),
        .cmd(g_cmd), .cmd_valid(g_cmd_valid), .cmd_ready(cmd_ready),
        .resp_valid(resp_valid), .resp_ok(resp_ok),
        .busy(g_busy), .game_over(g_game_over)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic await_offer(input string tag, input int budget, output int t);
        int n = 0;
        while (!o_valid && n < budget) begin
            step();
            n++;
        end
        t = cyc;
        check_eq({tag, " offered"}, 32'(o_valid), 32'd1);
    endtask

    // Called at an offer with cmd_ready high: transfer, then one response.
    task automatic transfer_and_respond(input logic ok);
        step();
        resp_valid = 1'b1;
        resp_ok    = ok;
        step();
        resp_valid = 1'b0;
        resp_ok    = 1'b0;
    endtask

    task automatic count_offers(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (o_valid) cnt++;
        end
    endtask

    int t, t1, t2, t3, t4, t5, t6, t7, w, e, extra;

    initial begin
        rst_m_n = 1'b0; rst_g_n = 1'b0; use_g = 1'b0;
        enable = 1'b1; cmd_ready = 1'b1;
        rotate = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        resp_valid = 1'b0; resp_ok = 1'b0;
        step(); step();

        // ---- reset values and power-up spawn ----
        check_eq("rst cmd", 32'(o_cmd), 32'(CMD_NONE));
        check_eq("rst valid", 32'(o_valid), 32'd0);
        check_eq("rst busy", 32'(o_busy), 32'd0);
        check_eq("rst over", 32'(o_over), 32'd0);
        rst_m_n = 1'b1;
        step();
        check_eq("spawn valid", 32'(o_valid), 32'd1);
        check_eq("spawn cmd", 32'(o_cmd), 32'(CMD_SPAWN));
        step();
        check_eq("wait busy", 32'(o_busy), 32'd1);
        check_eq("wait valid low", 32'(o_valid), 32'd0);
        resp_valid = 1'b1; resp_ok = 1'b1;
        step();
        resp_valid = 1'b0; resp_ok = 1'b0;
        check_eq("idle busy", 32'(o_busy), 32'd0);

        // ---- left+rotate together: ROTATE first, then LEFT ----
        rotate = 1'b1; left = 1'b1;
        step();
        rotate = 1'b0; left = 1'b0;
        check_eq("pulse t+1 valid", 32'(o_valid), 32'd0);
        step();
        check_eq("pulse t+2 valid", 32'(o_valid), 32'd1);
        check_eq("rotate first", 32'(o_cmd), 32'(CMD_ROTATE));
        transfer_and_respond(1'b1);
        check_eq("resp w+1 valid", 32'(o_valid), 32'd0);
        step();
        check_eq("resp w+2 valid", 32'(o_valid), 32'd1);
        check_eq("left second", 32'(o_cmd), 32'(CMD_LEFT));
        step();
        for (int i = 0; i < 3; i++) begin
            right = 1'b1; step();
            right = 1'b0; step();
        end
        check_eq("still waiting", 32'(o_busy), 32'd1);
        resp_valid = 1'b1; resp_ok = 1'b1;
        step();
        resp_valid = 1'b0; resp_ok = 1'b0;
        await_offer("right", 5, t);
        check_eq("right cmd", 32'(o_cmd), 32'(CMD_RIGHT));
        transfer_and_respond(1'b1);
        count_offers(12, extra);
        check_eq("single right", 32'(extra), 32'd0);

        // ---- failed DOWN -> LOCK -> SPAWN, keys during LOCK discarded ----
        down = 1'b1; step(); down = 1'b0;
        await_offer("down", 5, t);
        check_eq("down cmd", 32'(o_cmd), 32'(CMD_DOWN));
        step();
        resp_valid = 1'b1; resp_ok = 1'b0;
        step();
        resp_valid = 1'b0;
        check_eq("lock valid", 32'(o_valid), 32'd1);
        check_eq("lock cmd", 32'(o_cmd), 32'(CMD_LOCK));
        left = 1'b1; step(); left = 1'b0;
        rotate = 1'b1; step(); rotate = 1'b0;
        resp_valid = 1'b1; resp_ok = 1'b0;
        step();
        resp_valid = 1'b0;
        await_offer("respawn", 5, t);
        check_eq("respawn cmd", 32'(o_cmd), 32'(CMD_SPAWN));
        transfer_and_respond(1'b1);
        count_offers(12, extra);
        check_eq("flush after spawn", 32'(extra), 32'd0);

        // ---- cmd_ready low for 5 cycles ----
        cmd_ready = 1'b0;
        left = 1'b1; step(); left = 1'b0;
        await_offer("stall", 5, t);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall valid", 32'(o_valid), 32'd1);
            check_eq("stall cmd", 32'(o_cmd), 32'(CMD_LEFT));
            step();
        end
        cmd_ready = 1'b1;
        check_eq("stall end valid", 32'(o_valid), 32'd1);
        transfer_and_respond(1'b1);

        // ---- enable dropped during WAIT ----
        right = 1'b1; step(); right = 1'b0;
        await_offer("pre-disable", 5, t);
        step();
        enable = 1'b0;
        left = 1'b1; step(); left = 1'b0;
        resp_valid = 1'b1; resp_ok = 1'b1;
        step();
        resp_valid = 1'b0; resp_ok = 1'b0;
        check_eq("disabled resp done", 32'(o_busy), 32'd0);
        count_offers(10, extra);
        check_eq("no grant disabled", 32'(extra), 32'd0);
        enable = 1'b1;
        count_offers(10, extra);
        check_eq("dropped pulse", 32'(extra), 32'd0);

        // ---- spawn failure -> game over, async reset clears ----
        down = 1'b1; step(); down = 1'b0;
        await_offer("go down", 5, t);
        step();
        resp_valid = 1'b1; resp_ok = 1'b0;
        step();
        resp_valid = 1'b0;
        check_eq("go lock", 32'(o_cmd), 32'(CMD_LOCK));
        transfer_and_respond(1'b1);
        await_offer("go spawn", 5, t);
        check_eq("go spawn cmd", 32'(o_cmd), 32'(CMD_SPAWN));
        transfer_and_respond(1'b0);
        check_eq("game over set", 32'(o_over), 32'd1);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            {rotate, down, left, right} = 4'(i + 1);
            step();
            if (o_valid) extra++;
        end
        {rotate, down, left, right} = 4'b0;
        check_eq("over no offers", 32'(extra), 32'd0);
        check_eq("over sticky", 32'(o_over), 32'd1);
        rst_m_n = 1'b0;
        #1;
        check_eq("async rst over", 32'(o_over), 32'd0);
        check_eq("async rst cmd", 32'(o_cmd), 32'(CMD_NONE));
        step();

        // ---- gravity timing on the GRAVITY_DIV=8 instance ----
        use_g = 1'b1;
        rst_g_n = 1'b1;
        await_offer("g spawn", 5, t);
        check_eq("g spawn cmd", 32'(o_cmd), 32'(CMD_SPAWN));
        step();
        resp_valid = 1'b1; resp_ok = 1'b1; w = cyc;
        step();
        resp_valid = 1'b0; resp_ok = 1'b0;
        // counter restarts: 0..7 over w+1..w+8, pending at w+9, offer w+10
        await_offer("grav1", 20, t1);
        check_eq("grav1 latency", 32'(t1 - w), 32'd10);
        check_eq("grav1 cmd", 32'(o_cmd), 32'(CMD_DOWN));
        transfer_and_respond(1'b1);
        await_offer("grav2", 20, t2);
        check_eq("gravity period", 32'(t2 - t1), 32'd8);
        // user down pulsed during the gravity response; answered at count 5
        step();
        resp_valid = 1'b1; resp_ok = 1'b1; down = 1'b1;
        step();
        resp_valid = 1'b0; resp_ok = 1'b0; down = 1'b0;
        await_offer("udown", 5, t3);
        check_eq("udown latency", 32'(t3 - t2), 32'd3);
        step();
        resp_valid = 1'b1; resp_ok = 1'b1; w = cyc;
        step();
        resp_valid = 1'b0; resp_ok = 1'b0;
        await_offer("grav3", 20, t4);
        check_eq("gravity restart", 32'(t4 - w), 32'd10);
        // disable on the response cycle: counter frozen at 2
        step();
        resp_valid = 1'b1; resp_ok = 1'b1; enable = 1'b0;
        step();
        resp_valid = 1'b0; resp_ok = 1'b0;
        count_offers(30, extra);
        check_eq("frozen no offers", 32'(extra), 32'd0);
        enable = 1'b1; e = cyc;
        for (int i = 0; i < 5; i++) step();
        down = 1'b1; step(); down = 1'b0;     // same cycle as the wrap
        await_offer("grav4", 5, t5);
        check_eq("resume latency", 32'(t5 - e), 32'd7);
        check_eq("grav4 cmd", 32'(o_cmd), 32'(CMD_DOWN));
        transfer_and_respond(1'b1);
        await_offer("queued down", 5, t6);
        check_eq("queued down gap", 32'(t6 - t5), 32'd3);
        check_eq("queued down cmd", 32'(o_cmd), 32'(CMD_DOWN));
        step();
        resp_valid = 1'b1; resp_ok = 1'b1; w = cyc;
        step();
        resp_valid = 1'b0; resp_ok = 1'b0;
        await_offer("grav5", 20, t7);
        check_eq("grav5 latency", 32'(t7 - w), 32'd10);
        // blocked gravity drop -> lock -> failed spawn
        step();
        resp_valid = 1'b1; resp_ok = 1'b0;
        step();
        resp_valid = 1'b0;
        check_eq("g lock", 32'(o_cmd), 32'(CMD_LOCK));
        transfer_and_respond(1'b1);
        await_offer("g spawn2", 5, t);
        check_eq("g spawn2 cmd", 32'(o_cmd), 32'(CMD_SPAWN));
        transfer_and_respond(1'b0);
        check_eq("g over", 32'(o_over), 32'd1);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            down = i[0];
            step();
            if (o_valid) extra++;
        end
        down = 1'b0;
        check_eq("g over no offers", 32'(extra), 32'd0);
        check_eq("g over sticky", 32'(o_over), 32'd1);
        rst_g_n = 1'b0;
        #1;
        check_eq("g rst over", 32'(o_over), 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_tetris_move_scheduler
`default_nettype wire
